// File: rtl/uart_word_rx.sv
// UART 8N1 receiver with 16x oversampling.
// Two received bytes (low first, then high) are assembled into one word and presented with a
// single-cycle o_rx_done strobe. A low stop bit raises a single-cycle o_frame_err strobe and
// drops any half-assembled word.
module uart_word_rx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned TICK_DIV   = 326,
  parameter int unsigned WORD_WIDTH = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_rx,
  output logic [WORD_WIDTH-1:0] o_data,
  output logic                  o_rx_done,
  output logic                  o_frame_err
);

  localparam int unsigned TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int unsigned NW = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] TickLast = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] HalfLast = SW'(7);
  localparam logic [SW-1:0] BitLast  = SW'(15);
  localparam logic [SW-1:0] SbLast   = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] BitsLast = NW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  logic                  rx_meta_q;
  logic                  rx_s_q;
  logic [TW-1:0]         tick_cnt_q;
  logic [TW-1:0]         tick_cnt_d;
  logic                  tick;
  state_e                state_q;
  logic [SW-1:0]         s_cnt_q;
  logic [NW-1:0]         n_cnt_q;
  logic [DATA_BITS-1:0]  shift_q;
  logic [DATA_BITS-1:0]  low_q;
  logic                  idx_q;
  logic [WORD_WIDTH-1:0] data_q;
  logic                  done_q;
  logic                  ferr_q;

  // Two-flop synchroniser for the asynchronous line; idles high.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Free-running oversample tick; never realigned to the frame, so phase error is under one tick.
  always_comb begin
    tick       = (tick_cnt_q == TickLast);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  // Tick counter register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // Receive FSM plus byte-to-word assembly and registered strobes.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= StIdle;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      shift_q <= '0;
      low_q   <= '0;
      idx_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!rx_s_q) begin
            state_q <= StStart;
            s_cnt_q <= '0;
          end
        end
        StStart: begin
          if (tick) begin
            if (s_cnt_q == HalfLast) begin
              // Line must still be low at mid start bit, otherwise it was a glitch.
              if (!rx_s_q) begin
                state_q <= StData;
                s_cnt_q <= '0;
                n_cnt_q <= '0;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              s_cnt_q <= s_cnt_q + 1'b1;
            end
          end
        end
        StData: begin
          if (tick) begin
            if (s_cnt_q == BitLast) begin
              shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
              s_cnt_q <= '0;
              if (n_cnt_q == BitsLast) begin
                state_q <= StStop;
              end else begin
                n_cnt_q <= n_cnt_q + 1'b1;
              end
            end else begin
              s_cnt_q <= s_cnt_q + 1'b1;
            end
          end
        end
        StStop: begin
          if (tick) begin
            if (s_cnt_q == SbLast) begin
              state_q <= StIdle;
              if (rx_s_q) begin
                if (!idx_q) begin
                  low_q <= shift_q;
                  idx_q <= 1'b1;
                end else begin
                  data_q <= {shift_q, low_q};
                  done_q <= 1'b1;
                  idx_q  <= 1'b0;
                end
              end else begin
                ferr_q <= 1'b1;
                idx_q  <= 1'b0;
              end
            end else begin
              s_cnt_q <= s_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign o_data      = data_q;
  assign o_rx_done   = done_q;
  assign o_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_word_rx.sv
// Scoreboard bench for uart_word_rx at TICK_DIV=4 (64 clocks per bit).
module tb_uart_word_rx;

  localparam int unsigned TickDiv = 4;
  localparam int          BitClks = 64;

  typedef struct packed {
    logic        err;
    logic [15:0] data;
  } ev_t;

  logic        clk;
  logic        rst;
  logic        rx;
  logic [15:0] o_data;
  logic        o_rx_done;
  logic        o_frame_err;

  ev_t exp_q[$];
  int  checks;
  int  errors;

  uart_word_rx #(
    .DATA_BITS (8),
    .SB_TICK   (16),
    .TICK_DIV  (TickDiv),
    .WORD_WIDTH(16)
  ) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_rx       (rx),
    .o_data     (o_data),
    .o_rx_done  (o_rx_done),
    .o_frame_err(o_frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Hold the line at v for n clocks; changes land 1 time unit after a rising edge.
  task automatic drive_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    drive_bit(1'b0, BitClks);
    for (int i = 0; i < 8; i++) drive_bit(b[i], BitClks);
    if (stop_ok) begin
      drive_bit(1'b1, BitClks);
    end else begin
      // Low through the stop-bit centre, then released so it is not mistaken for a new start.
      drive_bit(1'b0, 48);
      drive_bit(1'b1, 16);
    end
  endtask

  task automatic expect_word(input logic [15:0] w);
    ev_t e;
    e.err  = 1'b0;
    e.data = w;
    exp_q.push_back(e);
  endtask

  task automatic expect_ferr(input logic [15:0] held);
    ev_t e;
    e.err  = 1'b1;
    e.data = held;
    exp_q.push_back(e);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    rx     = 1'b1;

    // Monitor: every strobe must match the head of the expected queue.
    fork
      forever begin
        @(negedge clk);
        if (o_rx_done && o_frame_err) begin
          checks++;
          errors++;
          $display("FAIL both_strobes: done=%b ferr=%b required not both", o_rx_done,
                   o_frame_err);
        end else if (o_rx_done || o_frame_err) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: done=%b ferr=%b data=%h required no strobe",
                     o_rx_done, o_frame_err, o_data);
          end else begin
            ev_t e;
            e = exp_q.pop_front();
            check("strobe_kind", {15'd0, o_frame_err}, {15'd0, e.err});
            check("strobe_data", o_data, e.data);
          end
        end
      end
    join_none

    // 1: reset, then a long quiet idle line.
    repeat (5) @(posedge clk);
    #1;
    check("reset_data", o_data, 16'h0000);
    check("reset_done", {15'd0, o_rx_done}, 16'h0000);
    check("reset_ferr", {15'd0, o_frame_err}, 16'h0000);
    rst = 1'b0;
    repeat (2000) @(posedge clk);
    #1;
    check("idle_data", o_data, 16'h0000);

    // 2: one word from two frames.
    expect_word(16'h1234);
    send_frame(8'h34, 1'b1);
    send_frame(8'h12, 1'b1);
    drive_bit(1'b1, 200);
    check("word_1234", o_data, 16'h1234);

    // 3: short glitch in idle.
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 300);
    check("glitch_hold", o_data, 16'h1234);

    // 4: framing error drops the byte, then a good pair.
    expect_ferr(16'h1234);
    send_frame(8'hAA, 1'b0);
    drive_bit(1'b1, 128);
    check("ferr_hold", o_data, 16'h1234);
    expect_word(16'h0155);
    send_frame(8'h55, 1'b1);
    send_frame(8'h01, 1'b1);
    drive_bit(1'b1, 200);

    // 5: reset during the high byte, then a clean pair.
    send_frame(8'h77, 1'b1);
    drive_bit(1'b0, BitClks);
    drive_bit(1'b1, BitClks);
    drive_bit(1'b0, BitClks);
    drive_bit(1'b1, 20);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    drive_bit(1'b1, 300);
    check("abort_reset_data", o_data, 16'h0000);
    expect_word(16'hABCD);
    send_frame(8'hCD, 1'b1);
    send_frame(8'hAB, 1'b1);
    drive_bit(1'b1, 200);

    // 6: four back-to-back frames.
    expect_word(16'h0201);
    expect_word(16'h0403);
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    send_frame(8'h03, 1'b1);
    send_frame(8'h04, 1'b1);
    drive_bit(1'b1, 300);
    check("b2b_last", o_data, 16'h0403);

    check("queue_drained", 16'(exp_q.size()), 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
